soc_system_clkgen_n: RTL and testbench

//   N-channel programmable clock/clock-enable generator for the SoC fabric. Successor to the fixed 4-output PLL wrapper:

---
 rtl/soc_system_clkgen_n_if.sv | 24 ++
 rtl/soc_system_clkgen_n.sv | 166 ++++++++++++++++
 tb/tb_soc_system_clkgen_n.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_system_clkgen_n_if.sv
// rtl/soc_system_clkgen_n_if.sv - config write port of the programmable clock generator
interface soc_system_clkgen_n_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_high;
    logic [DIV_W-1:0] cfg_phase;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase,
        output cfg_ready
    );
endinterface

// File: rtl/soc_system_clkgen_n.sv
// rtl/soc_system_clkgen_n.sv - N-channel counter-based clock/clock-enable generator with lock FSM
// Runtime reconfiguration through the cfg port exists only when CLKGEN_DYN_RECFG_EN is defined.
module soc_system_clkgen_n #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 1024,
    parameter int DEF_DIV     = 2,
    parameter int DEF_HIGH    = 1,
    parameter int DEF_PHASE   = 0
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  en,
    soc_system_clkgen_n_if.slave  cfg,
    output logic [NUM_CH-1:0]     outclk,
    output logic [NUM_CH-1:0]     outce,
    output logic                  locked
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {ST_RESET, ST_SETTLE, ST_RUN, ST_HALT} state_t;

    state_t            state;
    logic [LK_W-1:0]   lock_cnt;
    logic [DIV_W-1:0]  cnt      [NUM_CH];
    logic [DIV_W-1:0]  ch_div   [NUM_CH];
    logic [DIV_W-1:0]  ch_high  [NUM_CH];
    logic [DIV_W-1:0]  ch_phase [NUM_CH];
    logic [DIV_W-1:0]  eff_div  [NUM_CH];
    logic [DIV_W-1:0]  eff_phase[NUM_CH];
    logic [NUM_CH-1:0] apply_ch;
    logic [DIV_W-1:0]  ap_div, ap_high, ap_phase;

    function automatic logic [DIV_W-1:0] preload(input logic [DIV_W-1:0] d, input logic [DIV_W-1:0] p);
        return (p == '0 || p >= d) ? '0 : d - p;
    endfunction

`ifdef CLKGEN_DYN_RECFG_EN
    logic             pending;
    logic [CH_W-1:0]  sh_ch;
    logic [DIV_W-1:0] sh_div, sh_high, sh_phase;
    logic             ch_in_range;

    localparam logic [CH_W:0] NUM_CH_L = NUM_CH[CH_W:0];

    assign ch_in_range   = ({1'b0, cfg.cfg_ch} < NUM_CH_L);
    assign cfg.cfg_ready = (state != ST_RESET) && !pending;
    assign ap_div        = sh_div;
    assign ap_high       = sh_high;
    assign ap_phase      = sh_phase;

    // In RUN an update lands only on the target's last count so the period it interrupts is never shortened.
    always_comb begin
        apply_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            apply_ch[i] = pending && (sh_ch == CH_W'(i)) &&
                          (state != ST_RUN || ch_div[i] == '0 || cnt[i] == ch_div[i] - DIV_W'(1));
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            sh_ch    <= '0;
            sh_div   <= '0;
            sh_high  <= '0;
            sh_phase <= '0;
        end else if (|apply_ch) begin
            pending <= 1'b0;
        end else if (cfg.cfg_valid && cfg.cfg_ready && ch_in_range) begin
            pending  <= 1'b1;
            sh_ch    <= cfg.cfg_ch;
            sh_div   <= cfg.cfg_div;
            sh_high  <= cfg.cfg_high;
            sh_phase <= cfg.cfg_phase;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg    = ^{cfg.cfg_valid, cfg.cfg_ch, cfg.cfg_div, cfg.cfg_high, cfg.cfg_phase};
    assign cfg.cfg_ready = 1'b0;
    assign apply_ch      = '0;
    assign ap_div        = '0;
    assign ap_high       = '0;
    assign ap_phase      = '0;
`endif

    // Values an update applied on this same edge would install, so a SETTLE->RUN preload sees them.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            eff_div[i]   = apply_ch[i] ? ap_div   : ch_div[i];
            eff_phase[i] = apply_ch[i] ? ap_phase : ch_phase[i];
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state    <= ST_RESET;
            lock_cnt <= '0;
            locked   <= 1'b0;
            outclk   <= '0;
            outce    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]      <= '0;
                ch_div[i]   <= DIV_W'(DEF_DIV);
                ch_high[i]  <= DIV_W'(DEF_HIGH);
                ch_phase[i] <= DIV_W'(DEF_PHASE);
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (apply_ch[i]) begin
                    ch_div[i]   <= ap_div;
                    ch_high[i]  <= ap_high;
                    ch_phase[i] <= ap_phase;
                end
            end
            case (state)
                ST_RESET: begin
                    state    <= ST_SETTLE;
                    lock_cnt <= '0;
                end
                ST_SETTLE: begin
                    if (!en) begin
                        lock_cnt <= '0;
                    end else if (lock_cnt == LK_LAST) begin
                        state  <= ST_RUN;
                        locked <= 1'b1;
                        for (int i = 0; i < NUM_CH; i++) begin
                            cnt[i] <= preload(eff_div[i], eff_phase[i]);
                        end
                    end else begin
                        lock_cnt <= lock_cnt + LK_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state  <= ST_HALT;
                        locked <= 1'b0;
                        outclk <= '0;
                        outce  <= '0;
                        for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
                    end else begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            outclk[i] <= (ch_div[i] != '0) && (cnt[i] < ch_high[i]);
                            outce[i]  <= (ch_div[i] != '0) && (cnt[i] == '0) && (ch_high[i] != '0);
                            if (apply_ch[i] || ch_div[i] == '0 || cnt[i] == ch_div[i] - DIV_W'(1))
                                cnt[i] <= '0;
                            else
                                cnt[i] <= cnt[i] + DIV_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    if (en) begin
                        state    <= ST_SETTLE;
                        lock_cnt <= '0;
                    end
                end
                default: state <= ST_RESET;
            endcase
        end
    end
endmodule

// File: tb/tb_soc_system_clkgen_n.sv
// tb/tb_soc_system_clkgen_n.sv - directed self-checking bench for soc_system_clkgen_n
module tb_soc_system_clkgen_n;
    localparam int NUM_CH = 3;
    localparam int DIV_W  = 16;
    localparam int LOCK   = 16;
`ifdef CLKGEN_DYN_RECFG_EN
    localparam logic DYN = 1'b1;
`else
    localparam logic DYN = 1'b0;
`endif

    logic              refclk = 1'b0;
    logic              rst_n  = 1'b0;
    logic              en     = 1'b0;
    logic [NUM_CH-1:0] outclk;
    logic [NUM_CH-1:0] outce;
    logic              locked;
    int                errors = 0;
    int                checks = 0;

    soc_system_clkgen_n_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) cfg_if ();

    soc_system_clkgen_n #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK),
        .DEF_DIV(2), .DEF_HIGH(1), .DEF_PHASE(0)
    ) dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .en    (en),
        .cfg   (cfg_if),
        .outclk(outclk),
        .outce (outce),
        .locked(locked)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic cfg_write(input int ch, input int div, input int high, input int phase);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'(ch);
        cfg_if.cfg_div   = 16'(div);
        cfg_if.cfg_high  = 16'(high);
        cfg_if.cfg_phase = 16'(phase);
    endtask

    task automatic cfg_idle();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (cfg_if.cfg_ready) break;
            tick(1);
        end
        check(tag, 32'(cfg_if.cfg_ready), 32'd1);
    endtask

    task automatic wait_ce0(input string tag);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (outce[0]) break;
        end
        check(tag, 32'(outce[0]), 32'd1);
    endtask

    logic [1:0] recfg_tab [10];
    logic       acc;
    int         nce;
    int         c;

    initial begin
        recfg_tab = '{2'b10, 2'b00, 2'b00, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11};
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_high  = '0;
        cfg_if.cfg_phase = '0;

        rst_n = 1'b0;
        en    = 1'b1;
        tick(2);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_outclk", 32'(outclk), 32'd0);
        check("rst_outce",  32'(outce),  32'd0);
        check("rst_ready",  32'(cfg_if.cfg_ready), 32'd0);

        rst_n = 1'b1;
        tick(1);
        check("settle_ready", 32'(cfg_if.cfg_ready), 32'(DYN));
        tick(15);
        check("lock_early", 32'(locked), 32'd0);
        tick(1);
        check("lock_at_17", 32'(locked), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check($sformatf("def_outclk%0d", k), 32'(outclk), (k % 2 == 0) ? 32'h7 : 32'h0);
            check($sformatf("def_outce%0d", k),  32'(outce),  (k % 2 == 0) ? 32'h7 : 32'h0);
        end

        en = 1'b0;
        tick(1);
        check("halt_locked", 32'(locked), 32'd0);
        check("halt_outclk", 32'(outclk), 32'd0);

`ifdef CLKGEN_DYN_RECFG_EN
        cfg_write(1, 5, 2, 3);
        tick(1);
        cfg_idle();
        check("halt_pending", 32'(cfg_if.cfg_ready), 32'd0);
        tick(1);
        check("halt_applied", 32'(cfg_if.cfg_ready), 32'd1);
`else
        cfg_write(0, 5, 3, 1);
`endif
        en = 1'b1;
        tick(16);
        check("relock_early", 32'(locked), 32'd0);
        tick(1);
        check("relock", 32'(locked), 32'd1);

`ifdef CLKGEN_DYN_RECFG_EN
        for (int k = 0; k < 10; k++) begin
            tick(1);
            c = (2 + k) % 5;
            check($sformatf("phase_ch1_%0d", k), 32'({outclk[1], outce[1]}), 32'({c < 2, c == 0}));
        end

        cfg_write(0, 4, 2, 0);
        tick(1);
        cfg_idle();
        wait_ready("recfg1_ready");
        wait_ce0("recfg_sync");
        cfg_write(0, 6, 3, 0);
        for (int e = 0; e < 10; e++) begin
            tick(1);
            if (e == 0) cfg_idle();
            check($sformatf("recfg_ch0_%0d", e + 1), 32'({outclk[0], outce[0]}), 32'(recfg_tab[e]));
            if (e == 1) check("recfg_held",  32'(cfg_if.cfg_ready), 32'd0);
            if (e == 2) check("recfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
        end

        cfg_write(2, 0, 1, 0);
        tick(1);
        cfg_idle();
        wait_ready("div0_ready");
        tick(2);
        acc = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            acc = acc | outclk[2] | outce[2];
        end
        check("div0_off", 32'(acc), 32'd0);

        cfg_write(2, 1, 1, 0);
        tick(1);
        cfg_idle();
        wait_ready("div1_ready");
        tick(1);
        acc = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            acc = acc & outclk[2] & outce[2];
        end
        check("div1_const", 32'(acc), 32'd1);

        cfg_write(2, 4, 9, 0);
        tick(1);
        cfg_idle();
        wait_ready("hi9_ready");
        tick(1);
        acc = 1'b1;
        nce = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            acc = acc & outclk[2];
            nce += int'(outce[2]);
        end
        check("hi9_const", 32'(acc), 32'd1);
        check("hi9_ce_count", 32'(nce), 32'd2);

        cfg_write(0, 4, 2, 0);
        tick(1);
        cfg_write(0, 2, 1, 0);
        tick(1);
        check("b2b_held", 32'(cfg_if.cfg_ready), 32'd0);
        wait_ready("b2b_first_done");
        tick(1);
        check("b2b_second_pending", 32'(cfg_if.cfg_ready), 32'd0);
        cfg_idle();
        wait_ready("b2b_second_done");
        wait_ce0("b2b_sync");
        tick(1);
        check("b2b_div2_lo", 32'(outclk[0]), 32'd0);
        tick(1);
        check("b2b_div2_hi", 32'({outclk[0], outce[0]}), 32'b11);

        cfg_write(3, 5, 2, 0);
        tick(1);
        check("oor_ready", 32'(cfg_if.cfg_ready), 32'd1);
        cfg_idle();
        tick(1);
        check("oor_ready2", 32'(cfg_if.cfg_ready), 32'd1);

        cfg_write(1, 7, 1, 0);
        tick(1);
        cfg_idle();
        check("pre_rst_pending", 32'(cfg_if.cfg_ready), 32'd0);
`else
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check($sformatf("fixed_outclk%0d", k), 32'(outclk), (k % 2 == 0) ? 32'h7 : 32'h0);
            check($sformatf("fixed_ready%0d", k),  32'(cfg_if.cfg_ready), 32'd0);
        end
        cfg_idle();
`endif

        rst_n = 1'b0;
        tick(1);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_outclk", 32'(outclk), 32'd0);
        check("midrst_ready",  32'(cfg_if.cfg_ready), 32'd0);
        rst_n = 1'b1;
        tick(1);
        check("midrst_ready_back", 32'(cfg_if.cfg_ready), 32'(DYN));
        tick(16);
        check("midrst_relock", 32'(locked), 32'd1);
        tick(1);
        check("midrst_def_hi", 32'(outclk), 32'h7);
        tick(1);
        check("midrst_def_lo", 32'(outclk), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
